printing_grid_loader: RTL and testbench



---
 rtl/printing_grid_loader_if.sv | 28 ++
 rtl/printing_grid_loader.sv | 176 +++++++++++++++++
 tb/tb_printing_grid_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/printing_grid_loader_if.sv
// Byte-stream input and row-write output bundle of the printing grid loader.
// The loader connects through the slave modport; the stream source and row bank use master.
interface printing_grid_loader_if #(
  parameter int WIDTH = 140
);
  logic             start;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic             wr_en;
  logic [7:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [7:0]       rows_loaded;
  logic [14:0]      roll_count;
  logic             finished;
  logic             error;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data, rows_loaded, roll_count, finished, error
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data, rows_loaded, roll_count, finished, error
  );
endinterface

// File: rtl/printing_grid_loader.sv
// Packs an ASCII '@'/'.' grid stream into WIDTH-bit row words (first char = MSB)
// and writes one row per line into the roll bank, counting rolls and flagging bad input.
module printing_grid_loader #(
  parameter int WIDTH  = 140,
  parameter int HEIGHT = 140
) (
  input logic                   clk,
  input logic                   rst,
  printing_grid_loader_if.slave bus
);
  localparam int COLW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2, ERROR = 2'd3} state_t;

  state_t           state_r;
  logic [COLW-1:0]  col_r;
  logic [WIDTH-1:0] buf_r;
  logic             in_ready_r;
  logic             wr_en_r;
  logic [7:0]       wr_addr_r;
  logic [WIDTH-1:0] wr_data_r;
  logic [7:0]       rows_r;
  logic [14:0]      roll_r;
  logic             finished_r;
  logic             error_r;

  logic [COLW-1:0]  col_nxt_s;
  logic [WIDTH-1:0] buf_nxt_s;
  logic [WIDTH-1:0] mask_s;
  logic             err_s;
  logic             commit_s;
  logic             accept_s;

  function automatic logic [14:0] popcount(input logic [WIDTH-1:0] row);
    logic [14:0] cnt;
    cnt = 15'd0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {14'd0, row[i]};
    end
    return cnt;
  endfunction

  assign accept_s = bus.in_valid && in_ready_r;
  assign mask_s   = MSB_MASK >> col_r;

  // Classify the incoming byte and compute the next column/buffer and commit/error flags.
  always_comb begin
    col_nxt_s = col_r;
    buf_nxt_s = buf_r;
    err_s     = 1'b0;
    commit_s  = 1'b0;
    case (bus.in_data)
      8'h40, 8'h2E: begin
        if (col_r != COLW'(WIDTH)) begin
          buf_nxt_s = (bus.in_data == 8'h40) ? (buf_r | mask_s) : (buf_r & ~mask_s);
          col_nxt_s = col_r + {{(COLW-1){1'b0}}, 1'b1};
        end else begin
          err_s = 1'b1;
        end
      end
      8'h0A: begin
        if (col_r == COLW'(WIDTH)) begin
          commit_s = 1'b1;
        end else if (col_r != {COLW{1'b0}}) begin
          err_s = 1'b1;
        end else begin
          commit_s = 1'b0;
        end
      end
      8'h0D: begin
        err_s = 1'b0;
      end
      default: begin
        err_s = 1'b1;
      end
    endcase
    // A final line without a trailing newline still commits.
    if (!err_s && bus.in_last && (col_nxt_s == COLW'(WIDTH))) begin
      commit_s = 1'b1;
    end else begin
      commit_s = commit_s;
    end
  end

  // Load FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      col_r      <= '0;
      buf_r      <= '0;
      in_ready_r <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= 8'd0;
      wr_data_r  <= '0;
      rows_r     <= 8'd0;
      roll_r     <= 15'd0;
      finished_r <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      case (state_r)
        IDLE, DONE, ERROR: begin
          if (bus.start) begin
            state_r    <= LOAD;
            col_r      <= '0;
            buf_r      <= '0;
            in_ready_r <= 1'b1;
            rows_r     <= 8'd0;
            roll_r     <= 15'd0;
            finished_r <= 1'b0;
            error_r    <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        LOAD: begin
          if (accept_s) begin
            if (err_s) begin
              state_r    <= ERROR;
              in_ready_r <= 1'b0;
              finished_r <= 1'b1;
              error_r    <= 1'b1;
            end else if (commit_s) begin
              wr_en_r   <= 1'b1;
              wr_addr_r <= rows_r;
              wr_data_r <= buf_nxt_s;
              rows_r    <= rows_r + 8'd1;
              roll_r    <= roll_r + popcount(buf_nxt_s);
              buf_r     <= '0;
              col_r     <= '0;
              if (rows_r == 8'(HEIGHT - 1)) begin
                state_r    <= DONE;
                in_ready_r <= 1'b0;
                finished_r <= 1'b1;
              end else if (bus.in_last) begin
                state_r    <= ERROR;
                in_ready_r <= 1'b0;
                finished_r <= 1'b1;
                error_r    <= 1'b1;
              end else begin
                state_r <= LOAD;
              end
            end else begin
              buf_r <= buf_nxt_s;
              col_r <= col_nxt_s;
              if (bus.in_last) begin
                state_r    <= ERROR;
                in_ready_r <= 1'b0;
                finished_r <= 1'b1;
                error_r    <= 1'b1;
              end else begin
                state_r <= LOAD;
              end
            end
          end else begin
            state_r <= LOAD;
          end
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.wr_en       = wr_en_r;
  assign bus.wr_addr     = wr_addr_r;
  assign bus.wr_data     = wr_data_r;
  assign bus.rows_loaded = rows_r;
  assign bus.roll_count  = roll_r;
  assign bus.finished    = finished_r;
  assign bus.error       = error_r;
endmodule

// File: tb/tb_printing_grid_loader.sv
// Directed bench for printing_grid_loader on a 4x3 grid.
module tb_printing_grid_loader;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  bit   gaps_en;

  printing_grid_loader_if #(.WIDTH(4)) bus ();

  printing_grid_loader #(.WIDTH(4), .HEIGHT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("start_rows", {24'd0, bus.rows_loaded}, 32'd0);
    chk("start_finished", {31'd0, bus.finished}, 32'd0);
  endtask

  task automatic byte_step(input logic [7:0] b, input bit last, input bit we,
                           input logic [7:0] addr, input logic [3:0] data);
    if (gaps_en) begin
      repeat ($urandom_range(0, 1)) tick();
    end
    chk("in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("wr_en", {31'd0, bus.wr_en}, {31'd0, we});
    if (we) begin
      chk("wr_addr", {24'd0, bus.wr_addr}, {24'd0, addr});
      chk("wr_data", {28'd0, bus.wr_data}, {28'd0, data});
    end
  endtask

  // Sends a line; last/we/addr/data apply to its final character only.
  task automatic line(input string s, input bit last, input bit we,
                      input logic [7:0] addr, input logic [3:0] data);
    for (int i = 0; i < s.len(); i++) begin
      if (i == s.len() - 1) byte_step(s[i], last, we, addr, data);
      else                  byte_step(s[i], 1'b0, 1'b0, 8'd0, 4'd0);
    end
  endtask

  task automatic end_state(input string tag, input bit fin, input bit err,
                           input logic [7:0] rows, input logic [14:0] rolls);
    chk({tag, "_finished"}, {31'd0, bus.finished}, {31'd0, fin});
    chk({tag, "_error"}, {31'd0, bus.error}, {31'd0, err});
    chk({tag, "_rows"}, {24'd0, bus.rows_loaded}, {24'd0, rows});
    chk({tag, "_rolls"}, {17'd0, bus.roll_count}, {17'd0, rolls});
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
  endtask

  task automatic reset_state(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, bus.wr_en}, 32'd0);
    chk({tag, "_wr_addr"}, {24'd0, bus.wr_addr}, 32'd0);
    chk({tag, "_wr_data"}, {28'd0, bus.wr_data}, 32'd0);
    chk({tag, "_rows"}, {24'd0, bus.rows_loaded}, 32'd0);
    chk({tag, "_rolls"}, {17'd0, bus.roll_count}, 32'd0);
    chk({tag, "_finished"}, {31'd0, bus.finished}, 32'd0);
    chk({tag, "_error"}, {31'd0, bus.error}, 32'd0);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    gaps_en      = 1'b0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    reset_state("reset");

    // Basic grid, LF endings, in_last on final newline.
    do_start();
    line("@.@@\n", 1'b0, 1'b1, 8'd0, 4'b1011);
    line("....\n", 1'b0, 1'b1, 8'd1, 4'b0000);
    line("@@@@\n", 1'b1, 1'b1, 8'd2, 4'b1111);
    end_state("t1", 1'b1, 1'b0, 8'd3, 15'd7);
    tick();
    chk("t1_wr_en_drop", {31'd0, bus.wr_en}, 32'd0);
    chk("t1_wr_addr_hold", {24'd0, bus.wr_addr}, 32'd2);
    chk("t1_wr_data_hold", {28'd0, bus.wr_data}, 32'hf);

    // CRLF endings, blank line, no final newline.
    do_start();
    chk("t2_rolls_clear", {17'd0, bus.roll_count}, 32'd0);
    line("@.@@\r\n", 1'b0, 1'b1, 8'd0, 4'b1011);
    line("\r\n", 1'b0, 1'b0, 8'd0, 4'd0);
    line("....\r\n", 1'b0, 1'b1, 8'd1, 4'b0000);
    line("@@@@", 1'b1, 1'b1, 8'd2, 4'b1111);
    end_state("t2", 1'b1, 1'b0, 8'd3, 15'd7);

    // Short line.
    do_start();
    line("@.@\n", 1'b0, 1'b0, 8'd0, 4'd0);
    end_state("t3", 1'b1, 1'b1, 8'd0, 15'd0);
    tick();
    chk("t3_in_ready_hold", {31'd0, bus.in_ready}, 32'd0);

    // Long line.
    do_start();
    line("@.@@@", 1'b0, 1'b0, 8'd0, 4'd0);
    end_state("t4a", 1'b1, 1'b1, 8'd0, 15'd0);

    // Stray byte after one good row.
    do_start();
    line("@.@@\n", 1'b0, 1'b1, 8'd0, 4'b1011);
    line("x", 1'b0, 1'b0, 8'd0, 4'd0);
    end_state("t4b", 1'b1, 1'b1, 8'd1, 15'd3);

    // in_last on a blank newline before HEIGHT rows.
    do_start();
    line("@@@@\n", 1'b0, 1'b1, 8'd0, 4'b1111);
    line("\n", 1'b1, 1'b0, 8'd0, 4'd0);
    end_state("t5", 1'b1, 1'b1, 8'd1, 15'd4);

    // Gapped input, reset mid-row 2, then reload.
    gaps_en = 1'b1;
    do_start();
    line("@@@@\n", 1'b0, 1'b1, 8'd0, 4'b1111);
    line("@..@\n", 1'b0, 1'b1, 8'd1, 4'b1001);
    line("@@", 1'b0, 1'b0, 8'd0, 4'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_state("t6_rst");
    tick();
    chk("t6_idle_ready", {31'd0, bus.in_ready}, 32'd0);
    do_start();
    line("..@.\n", 1'b0, 1'b1, 8'd0, 4'b0010);
    line(".@..\n", 1'b0, 1'b1, 8'd1, 4'b0100);
    line("@@.@\n", 1'b1, 1'b1, 8'd2, 4'b1101);
    end_state("t6", 1'b1, 1'b0, 8'd3, 15'd5);
    gaps_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
